lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
- Load/store initiator that sits between the core's memory stage and the byte-addressed data RAM port.
- Accepts one load or store request at a time over a valid/ready handshake.
- Drives the RAM port (rwtyp/addr/data/wren/rden) and captures the RAM's one-cycle-latency read data.
- Sign- or zero-extends load data and returns a single-cycle response pulse; misaligned and illegal requests are rejected without touching memory.

Parameters:
- ADDR_WIDTH, 32, byte address width on both sides.
- DATA_WIDTH, 32, data width; fixed at 32 for RV32.

Ports:
- clk  input  1  clock.
- rstn  input  1  asynchronous active-low reset.
- req_valid  input  1  core request valid.
- req_ready  output  1  block can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32 funct3. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- req_addr  input  ADDR_WIDTH  byte address.
- req_wdata  input  DATA_WIDTH  store data, right-aligned (unshifted).
- resp_valid  output  1  one-cycle response pulse.
- resp_err  output  1  request rejected (misaligned or illegal funct3); qualified by resp_valid.
- resp_rdata  output  DATA_WIDTH  extended load data; 0 for stores and errors.
- mem_rwtyp  output  3  access type to RAM (= funct3).
- mem_addr  output  ADDR_WIDTH  byte address to RAM.
- mem_data  output  DATA_WIDTH  unshifted store data; RAM applies the lane shift.
- mem_wren  output  1  write strobe.
- mem_rden  output  1  read strobe.
- mem_q  input  DATA_WIDTH  RAM read data. Valid the cycle after mem_rden, already lane-shifted and zero-extended; 0 when not reading.

Behaviour:
- Reset: asynchronous, active-low.
  - State returns to IDLE.
  - resp_valid, resp_err, resp_rdata, mem_rwtyp, mem_addr, mem_data, mem_wren and mem_rden all reset to 0.
  - All outputs are registered except req_ready.
- req_ready = (state == IDLE), combinational; it is 1 during reset.
- Accept: handshake completes in cycle T when req_valid & req_ready. The request fields are latched at the end of T.
- Error check, performed at accept:
  - Misaligned: funct3[1:0]==01 with addr[0]!=0, or funct3[1:0]==10 with addr[1:0]!=0.
  - Illegal funct3: loads 011, 110, 111; stores any value with funct3[2]==1, or 011.
- States:
  - IDLE: on accept with error -> RESP (err). On accept of a valid load or store -> ISSUE. Otherwise stay.
  - ISSUE (T+1): drive mem_addr, mem_rwtyp and mem_data. For a store, mem_wren=1 for exactly this cycle, then -> RESP. For a load, mem_rden=1 for exactly this cycle, then -> CAPTURE.
  - CAPTURE (T+2): register mem_q through the extension logic into resp_rdata, then -> RESP.
  - RESP: resp_valid=1 for exactly one cycle, then -> IDLE. There is no response backpressure; the core must sample the pulse.
- Response cycle:
  - Error: resp_valid at T+1, resp_err=1, resp_rdata=0. mem_wren and mem_rden never assert.
  - Store: resp_valid at T+2, resp_rdata=0, resp_err=0.
  - Load: resp_valid at T+3.
- Extension of mem_q, keyed on the latched funct3:
  - 000 -> {{24{q[7]}}, q[7:0]}
  - 001 -> {{16{q[15]}}, q[15:0]}
  - 010 -> q
  - 100 -> {24'd0, q[7:0]}
  - 101 -> {16'd0, q[15:0]}
  - Upper bits of mem_q are masked regardless of their value.
- Strobes: mem_wren and mem_rden are never high together and are 0 outside ISSUE. mem_addr, mem_rwtyp and mem_data hold their last values when idle.
- Throughput:
  - One outstanding request.
  - Back-to-back accept spacing: 4 cycles for loads, 3 for stores, 2 for errors.
- Reset mid-operation: any in-flight request is dropped. No strobe and no resp_valid are produced after rstn deasserts.
- resp_rdata holds until the next response is loaded; its value is meaningful only while resp_valid=1.

Test Plan:
- SW 0xDEADBEEF @0x100, then LW @0x100 -> mem_wren one cycle at T+1. The load has mem_rden one cycle at its T+1 and resp_valid at its T+3 with resp_rdata=0xDEADBEEF, resp_err=0.
- SB 0x80 @0x103; LB @0x103 -> 0xFFFFFF80; LBU @0x103 -> 0x00000080. A following LW @0x100 shows only byte 3 changed (0x80ADBEEF).
- SH 0x8001 @0x102; LH @0x102 -> 0xFFFF8001; LHU @0x102 -> 0x00008001.
- LW @0x101 -> resp_valid at T+1 with resp_err=1, resp_rdata=0, no mem strobe. Load funct3=011 -> err. Store funct3=100 -> err.
- req_valid held high with two back-to-back loads -> req_ready low from T+1 to T+3; the second accept occurs at T+4. For two stores, the second accept occurs at T+3.
- Assert rstn low during CAPTURE of a load -> all outputs 0 immediately, no resp_valid after release, req_ready=1. The next request completes normally.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator between the core memory stage and the byte-addressed
// data RAM port. One request in flight; the RAM returns lane-shifted,
// zero-extended read data one cycle after mem_rden and this block applies
// the sign/zero extension selected by funct3.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | ready for a request; mem_* address/type/data hold last value
// ISSUE   | RAM address/type/data valid, one-cycle wren (store) or rden (load)
// CAPTURE | RAM read data valid on mem_q, extended into resp_rdata
// RESP    | resp_valid pulse (resp_err set for rejected requests)
module lsu_mem_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic                  resp_err,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic [2:0]            mem_rwtyp,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_wren,
  output logic                  mem_rden,
  input  logic [DATA_WIDTH-1:0] mem_q
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_err_q, resp_err_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic [2:0]            mem_rwtyp_q, mem_rwtyp_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
  logic                  mem_wren_q, mem_wren_d;
  logic                  mem_rden_q, mem_rden_d;

  logic                  accept;
  logic                  misaligned;
  logic                  illegal;
  logic                  req_err;
  logic [DATA_WIDTH-1:0] ext_q;

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid & req_ready;

  // Reject misaligned halfword/word accesses and funct3 codes RV32 does not define
  always_comb begin
    misaligned = 1'b0;
    illegal    = 1'b0;
    if (req_funct3[1:0] == 2'b01 && req_addr[0] != 1'b0) misaligned = 1'b1;
    if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) misaligned = 1'b1;
    if (req_we) begin
      illegal = req_funct3[2] | (req_funct3 == 3'b011);
    end else begin
      illegal = (req_funct3 == 3'b011) | (req_funct3 == 3'b110) | (req_funct3 == 3'b111);
    end
    req_err = misaligned | illegal;
  end

  // Extend RAM read data; upper lanes are masked even if the RAM drives them
  always_comb begin
    case (mem_rwtyp_q)
      3'b000:  ext_q = {{(DATA_WIDTH-8){mem_q[7]}}, mem_q[7:0]};
      3'b001:  ext_q = {{(DATA_WIDTH-16){mem_q[15]}}, mem_q[15:0]};
      3'b010:  ext_q = mem_q;
      3'b100:  ext_q = {{(DATA_WIDTH-8){1'b0}}, mem_q[7:0]};
      3'b101:  ext_q = {{(DATA_WIDTH-16){1'b0}}, mem_q[15:0]};
      default: ext_q = '0;
    endcase
  end

  // Next-state and next-output logic; strobes and resp_valid default low so they pulse
  always_comb begin
    state_d      = state_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = resp_rdata_q;
    mem_rwtyp_d  = mem_rwtyp_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    mem_wren_d   = 1'b0;
    mem_rden_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_err) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else begin
            state_d     = ISSUE;
            mem_rwtyp_d = req_funct3;
            mem_addr_d  = req_addr;
            mem_data_d  = req_wdata;
            mem_wren_d  = req_we;
            mem_rden_d  = ~req_we;
          end
        end
      end
      ISSUE: begin
        if (mem_wren_q) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = '0;
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = ext_q;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset drops any in-flight request
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_rwtyp_q  <= '0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      mem_wren_q   <= 1'b0;
      mem_rden_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      mem_rwtyp_q  <= mem_rwtyp_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      mem_wren_q   <= mem_wren_d;
      mem_rden_q   <= mem_rden_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_rwtyp  = mem_rwtyp_q;
  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign mem_wren   = mem_wren_q;
  assign mem_rden   = mem_rden_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a small byte-addressed RAM model.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [2:0]  mem_rwtyp;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_wren;
  logic        mem_rden;
  logic [31:0] mem_q;

  logic        garb;
  int          n_cmp = 0;
  int          n_mis = 0;

  lsu_mem_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata),
    .mem_rwtyp  (mem_rwtyp),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_wren   (mem_wren),
    .mem_rden   (mem_rden),
    .mem_q      (mem_q)
  );

  always #5 clk = ~clk;

  // RAM model: lane shift on write, zero-extended read one cycle after rden;
  // garb pollutes unused upper lanes to exercise the masking
  logic [7:0] ram [0:1023];
  always @(posedge clk) begin
    logic [9:0]  a;
    logic [31:0] rd;
    a = mem_addr[9:0];
    if (mem_wren) begin
      ram[a] <= mem_data[7:0];
      if (mem_rwtyp[1:0] != 2'b00) ram[a+10'd1] <= mem_data[15:8];
      if (mem_rwtyp[1:0] == 2'b10) begin
        ram[a+10'd2] <= mem_data[23:16];
        ram[a+10'd3] <= mem_data[31:24];
      end
    end
    if (mem_rden) begin
      case (mem_rwtyp[1:0])
        2'b00:   rd = {24'd0, ram[a]};
        2'b01:   rd = {16'd0, ram[a+10'd1], ram[a]};
        default: rd = {ram[a+10'd3], ram[a+10'd2], ram[a+10'd1], ram[a]};
      endcase
      if (garb && mem_rwtyp[1:0] == 2'b00) rd = rd | 32'hA5A5_A500;
      if (garb && mem_rwtyp[1:0] == 2'b01) rd = rd | 32'hA5A5_0000;
      mem_q <= rd;
    end else begin
      mem_q <= 32'd0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One request from IDLE; samples T+1..T+4 and returns in T+4 (IDLE again)
  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int exp_cyc, input logic exp_err, input logic [31:0] exp_rdata);
    logic [4:0]  rv_m, wr_m, rd_m, e_rv, e_wr, e_rd;
    logic        err_s;
    logic [31:0] rdata_s;
    rv_m = '0; wr_m = '0; rd_m = '0;
    e_rv = '0; e_rv[exp_cyc] = 1'b1;
    e_wr = (we && !exp_err) ? 5'b00010 : 5'b00000;
    e_rd = (!we && !exp_err) ? 5'b00010 : 5'b00000;
    err_s = 1'b0;
    rdata_s = 32'hFFFF_FFFF;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    chk({tag, " ready"}, {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (resp_valid) begin
        rv_m[k] = 1'b1;
        err_s   = resp_err;
        rdata_s = resp_rdata;
      end
      if (mem_wren) wr_m[k] = 1'b1;
      if (mem_rden) rd_m[k] = 1'b1;
      if (k < 4) begin
        @(posedge clk); #1;
      end
    end
    chk({tag, " resp_cycles"}, {27'd0, rv_m}, {27'd0, e_rv});
    chk({tag, " wren_cycles"}, {27'd0, wr_m}, {27'd0, e_wr});
    chk({tag, " rden_cycles"}, {27'd0, rd_m}, {27'd0, e_rd});
    chk({tag, " err"}, {31'd0, err_s}, {31'd0, exp_err});
    chk({tag, " rdata"}, rdata_s, exp_rdata);
  endtask

  initial begin
    logic [8:0] rdy_m, rv_m;
    int         stray;
    rstn = 1'b1; garb = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    #1 rstn = 1'b0;
    #10;
    chk("rst ready", {31'd0, req_ready}, 32'd1);
    chk("rst resp", {30'd0, resp_valid, resp_err}, 32'd0);
    chk("rst rdata", resp_rdata, 32'd0);
    chk("rst strobes", {29'd0, mem_rwtyp}, 32'd0);
    chk("rst addr_data", mem_addr | mem_data | {30'd0, mem_wren, mem_rden}, 32'd0);
    @(posedge clk); #1 rstn = 1'b1;
    @(posedge clk); #1;

    do_req("SW",        1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 2, 1'b0, 32'h0);
    do_req("LW",        1'b0, 3'b010, 32'h100, 32'h0,        3, 1'b0, 32'hDEADBEEF);
    do_req("SB",        1'b1, 3'b000, 32'h103, 32'h00000080, 2, 1'b0, 32'h0);
    do_req("LB",        1'b0, 3'b000, 32'h103, 32'h0,        3, 1'b0, 32'hFFFFFF80);
    do_req("LBU",       1'b0, 3'b100, 32'h103, 32'h0,        3, 1'b0, 32'h00000080);
    do_req("LW byte3",  1'b0, 3'b010, 32'h100, 32'h0,        3, 1'b0, 32'h80ADBEEF);
    do_req("LB pos",    1'b0, 3'b000, 32'h101, 32'h0,        3, 1'b0, 32'hFFFFFFBE);
    do_req("SH",        1'b1, 3'b001, 32'h102, 32'h00008001, 2, 1'b0, 32'h0);
    do_req("LH",        1'b0, 3'b001, 32'h102, 32'h0,        3, 1'b0, 32'hFFFF8001);
    do_req("LHU",       1'b0, 3'b101, 32'h102, 32'h0,        3, 1'b0, 32'h00008001);

    garb = 1'b1;
    do_req("LB mask",   1'b0, 3'b000, 32'h103, 32'h0,        3, 1'b0, 32'hFFFFFF80);
    do_req("LBU mask",  1'b0, 3'b100, 32'h100, 32'h0,        3, 1'b0, 32'h000000EF);
    do_req("LHU mask",  1'b0, 3'b101, 32'h102, 32'h0,        3, 1'b0, 32'h00008001);
    do_req("LH mask",   1'b0, 3'b001, 32'h100, 32'h0,        3, 1'b0, 32'hFFFFBEEF);
    garb = 1'b0;

    do_req("LW mis",    1'b0, 3'b010, 32'h101, 32'h0,        1, 1'b1, 32'h0);
    do_req("LD f011",   1'b0, 3'b011, 32'h100, 32'h0,        1, 1'b1, 32'h0);
    do_req("ST f100",   1'b1, 3'b100, 32'h100, 32'h12345678, 1, 1'b1, 32'h0);
    do_req("SH mis",    1'b1, 3'b001, 32'h101, 32'h00001234, 1, 1'b1, 32'h0);
    do_req("LD f110",   1'b0, 3'b110, 32'h100, 32'h0,        1, 1'b1, 32'h0);
    do_req("LW after",  1'b0, 3'b010, 32'h100, 32'h0,        3, 1'b0, 32'h8001BEEF);

    // Two back-to-back loads with req_valid held: accepts in cycles 0 and 4
    rdy_m = '0; rv_m = '0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100; req_wdata = 32'h0;
    for (int c = 0; c <= 8; c++) begin
      rdy_m[c] = req_ready;
      rv_m[c]  = resp_valid;
      if (c == 7) chk("b2b ld rdata", resp_rdata, 32'h8001BEEF);
      @(posedge clk); #1;
      if (c == 4) req_valid = 1'b0;
    end
    chk("b2b ld ready", {23'd0, rdy_m}, {23'd0, 9'b1_0001_0001});
    chk("b2b ld resp", {23'd0, rv_m}, {23'd0, 9'b0_1000_1000});

    // Two back-to-back stores: accepts in cycles 0 and 3
    rdy_m = '0; rv_m = '0;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h200; req_wdata = 32'h12345678;
    for (int c = 0; c <= 6; c++) begin
      rdy_m[c] = req_ready;
      rv_m[c]  = resp_valid;
      @(posedge clk); #1;
      if (c == 0) begin
        req_addr = 32'h204; req_wdata = 32'hCAFEF00D;
      end
      if (c == 3) req_valid = 1'b0;
    end
    chk("b2b st ready", {23'd0, rdy_m}, {23'd0, 9'b0_0100_1001});
    chk("b2b st resp", {23'd0, rv_m}, {23'd0, 9'b0_0010_0100});
    do_req("LW 204",    1'b0, 3'b010, 32'h204, 32'h0,        3, 1'b0, 32'hCAFEF00D);

    // Reset asserted during CAPTURE of a load
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1 rstn = 1'b0;
    #1;
    chk("midrst ready", {31'd0, req_ready}, 32'd1);
    chk("midrst resp", {30'd0, resp_valid, resp_err}, 32'd0);
    chk("midrst rdata", resp_rdata, 32'd0);
    chk("midrst strobes", {27'd0, mem_rwtyp, mem_wren, mem_rden}, 32'd0);
    chk("midrst addr_data", mem_addr | mem_data, 32'd0);
    @(posedge clk); #1 rstn = 1'b1;
    stray = 0;
    for (int c = 0; c < 5; c++) begin
      if (resp_valid || mem_wren || mem_rden) stray++;
      @(posedge clk); #1;
    end
    chk("midrst stray", stray, 32'd0);
    chk("midrst ready after", {31'd0, req_ready}, 32'd1);
    do_req("LW post",   1'b0, 3'b010, 32'h200, 32'h0,        3, 1'b0, 32'h12345678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
